// File: rtl/param_regfile_if.sv
// Bus interface for param_regfile: write port, two read ports, clear
// request and status. clk/rst stay outside as plain module ports.
interface param_regfile_if #(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned ADDR_W = 5
);
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [ADDR_W-1:0] rd_addr1;
  logic [ADDR_W-1:0] rd_addr2;
  logic [DATA_W-1:0] rd_data1;
  logic [DATA_W-1:0] rd_data2;
  logic              clr_req;
  logic              busy;
  logic              wr_drop;

  modport master (
    output wr_en, wr_addr, wr_data, rd_addr1, rd_addr2, clr_req,
    input  rd_data1, rd_data2, busy, wr_drop
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, rd_addr1, rd_addr2, clr_req,
    output rd_data1, rd_data2, busy, wr_drop
  );
endinterface

// File: rtl/param_regfile.sv
// param_regfile: 2-read / 1-write register file with a sequential clear
// engine (one entry per cycle). Optional same-cycle write-to-read bypass
// is enabled by defining PARAM_REGFILE_BYPASS_EN; default build reads the
// stored (pre-write) value.
module param_regfile #(
  parameter int unsigned DATA_W   = 64,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned ZERO_REG = 1
) (
  input  logic           clk,
  input  logic           rst,
  param_regfile_if.slave bus
);
  localparam int unsigned DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_IDX = '1;

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_CLEAR = 1'b1;

  logic [0:0]        state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic              wr_drop_q, wr_drop_d;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;

  logic              zero1, zero2;

  // Next-state, clear index and storage write-port selection.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    wr_drop_d = 1'b0;
    mem_we    = 1'b0;
    mem_waddr = bus.wr_addr;
    mem_wdata = bus.wr_data;
    case (state_q)
      S_IDLE: begin
        // Writes to entry 0 are silently discarded when it is hardwired.
        if (bus.wr_en && !((ZERO_REG != 0) && (bus.wr_addr == '0))) begin
          mem_we = 1'b1;
        end
        if (bus.clr_req) begin
          state_d = S_CLEAR;
          idx_d   = '0;
        end
      end
      S_CLEAR: begin
        mem_we    = 1'b1;
        mem_waddr = idx_q;
        mem_wdata = '0;
        wr_drop_d = bus.wr_en;
        if (idx_q == LAST_IDX) begin
          state_d = S_IDLE;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      default: begin
        state_d = S_CLEAR;
        idx_d   = '0;
      end
    endcase
  end

  // Control state; reset parks the engine at the start of a full clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_CLEAR;
      idx_q     <= '0;
      wr_drop_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      wr_drop_q <= wr_drop_d;
    end
  end

  // Storage array; never reset directly, the clear engine zeroes it.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end

  assign zero1 = (ZERO_REG != 0) && (bus.rd_addr1 == '0);
  assign zero2 = (ZERO_REG != 0) && (bus.rd_addr2 == '0);

`ifdef PARAM_REGFILE_BYPASS_EN
  logic byp_v;
  assign byp_v = (state_q == S_IDLE) && bus.wr_en;
  assign bus.rd_data1 = zero1 ? '0 :
                        (byp_v && (bus.rd_addr1 == bus.wr_addr)) ? bus.wr_data :
                        mem_q[bus.rd_addr1];
  assign bus.rd_data2 = zero2 ? '0 :
                        (byp_v && (bus.rd_addr2 == bus.wr_addr)) ? bus.wr_data :
                        mem_q[bus.rd_addr2];
`else
  assign bus.rd_data1 = zero1 ? '0 : mem_q[bus.rd_addr1];
  assign bus.rd_data2 = zero2 ? '0 : mem_q[bus.rd_addr2];
`endif

  assign bus.busy    = (state_q == S_CLEAR);
  assign bus.wr_drop = wr_drop_q;
endmodule

// File: tb/tb_param_regfile.sv
// Directed testbench for param_regfile (DATA_W=64, ADDR_W=5, ZERO_REG=1).
module tb_param_regfile;
  logic clk;
  logic rst;
  int   n_assert;
  int   n_fail;
  int   cnt;
  logic [63:0] acc;
  logic [63:0] big;

  param_regfile_if #(.DATA_W(64), .ADDR_W(5)) bus ();

  param_regfile #(.DATA_W(64), .ADDR_W(5), .ZERO_REG(1)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Count edges until busy falls, bounded.
  task automatic count_busy(output int c);
    c = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      c++;
      if (bus.busy === 1'b0) break;
    end
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;
    big      = 64'hDEADBEEF_CAFEF00D;
    rst          = 1'b0;
    bus.wr_en    = 1'b0;
    bus.wr_addr  = '0;
    bus.wr_data  = '0;
    bus.rd_addr1 = '0;
    bus.rd_addr2 = '0;
    bus.clr_req  = 1'b0;

    // Asynchronous reset, before any clock edge
    #1 rst = 1'b1;
    #1;
    chk("rst_async_busy", {63'd0, bus.busy}, 64'd1);
    chk("rst_async_drop", {63'd0, bus.wr_drop}, 64'd0);
    tick();
    tick();
    rst = 1'b0;
    count_busy(cnt);
    chk("reset_clear_cycles", cnt, 64'd32);

    acc = '0;
    for (int i = 0; i < 32; i++) begin
      bus.rd_addr1 = i[4:0];
      bus.rd_addr2 = 5'(31 - i);
      #1;
      acc = acc | bus.rd_data1 | bus.rd_data2;
    end
    chk("reset_all_zero", acc, 64'd0);

    // Write to entry 7: same-cycle read, then next-cycle read
    bus.wr_en    = 1'b1;
    bus.wr_addr  = 5'd7;
    bus.wr_data  = big;
    bus.rd_addr1 = 5'd7;
    bus.rd_addr2 = 5'd7;
    #1;
`ifdef PARAM_REGFILE_BYPASS_EN
    chk("same_cycle_rd2", bus.rd_data2, big);
`else
    chk("same_cycle_rd2", bus.rd_data2, 64'd0);
`endif
    tick();
    bus.wr_en = 1'b0;
    #1;
    chk("next_cycle_rd1", bus.rd_data1, big);
    chk("next_cycle_rd2", bus.rd_data2, big);

    // Write to hardwired entry 0
    bus.wr_en    = 1'b1;
    bus.wr_addr  = 5'd0;
    bus.wr_data  = 64'h1234;
    bus.rd_addr1 = 5'd0;
    #1;
    chk("zero_reg_same_cycle", bus.rd_data1, 64'd0);
    tick();
    bus.wr_en = 1'b0;
    #1;
    chk("zero_reg_read", bus.rd_data1, 64'd0);
    chk("zero_reg_no_drop", {63'd0, bus.wr_drop}, 64'd0);

    // Fill entries 1..31 with value = index
    for (int i = 1; i < 32; i++) begin
      bus.wr_en   = 1'b1;
      bus.wr_addr = i[4:0];
      bus.wr_data = 64'(i);
      tick();
    end
    bus.wr_en    = 1'b0;
    bus.rd_addr1 = 5'd20;
    bus.rd_addr2 = 5'd7;
    #1;
    chk("fill_rd20", bus.rd_data1, 64'd20);
    chk("fill_rd7", bus.rd_data2, 64'd7);

    // Clear with a dropped write and an ignored clr_req mid-clear
    bus.clr_req = 1'b1;
    tick();
    bus.clr_req = 1'b0;
    #1;
    chk("clear_busy", {63'd0, bus.busy}, 64'd1);
    tick();
    tick();
    bus.rd_addr1 = 5'd1;
    bus.rd_addr2 = 5'd25;
    #1;
    chk("mid_clear_cleared", bus.rd_data1, 64'd0);
    chk("mid_clear_old", bus.rd_data2, 64'd25);
    bus.wr_en   = 1'b1;
    bus.wr_addr = 5'd20;
    bus.wr_data = 64'hFF;
    tick();
    bus.wr_en = 1'b0;
    #1;
    chk("drop_pulse", {63'd0, bus.wr_drop}, 64'd1);
    tick();
    chk("drop_pulse_end", {63'd0, bus.wr_drop}, 64'd0);
    bus.clr_req = 1'b1;
    tick();
    bus.clr_req = 1'b0;
    count_busy(cnt);
    chk("clear_no_restart", cnt, 64'd27);
    bus.rd_addr1 = 5'd20;
    bus.rd_addr2 = 5'd31;
    #1;
    chk("after_clear_rd20", bus.rd_data1, 64'd0);
    chk("after_clear_rd31", bus.rd_data2, 64'd0);

    // Write and clear request in the same IDLE cycle
    bus.wr_en   = 1'b1;
    bus.wr_addr = 5'd3;
    bus.wr_data = 64'hA5A5;
    bus.clr_req = 1'b1;
    bus.rd_addr1 = 5'd3;
    tick();
    bus.wr_en   = 1'b0;
    bus.clr_req = 1'b0;
    #1;
    chk("wr_clr_new_value", bus.rd_data1, 64'hA5A5);
    chk("wr_clr_busy", {63'd0, bus.busy}, 64'd1);
    chk("wr_clr_no_drop", {63'd0, bus.wr_drop}, 64'd0);
    count_busy(cnt);
    chk("wr_clr_cycles", cnt, 64'd32);
    chk("wr_clr_zeroed", bus.rd_data1, 64'd0);

    // Reset at clear index 15 restarts the clear
    bus.wr_en   = 1'b1;
    bus.wr_addr = 5'd30;
    bus.wr_data = 64'h55;
    tick();
    bus.wr_en   = 1'b0;
    bus.clr_req = 1'b1;
    tick();
    bus.clr_req = 1'b0;
    for (int i = 0; i < 15; i++) tick();
    rst = 1'b1;
    #1;
    chk("mid_rst_busy", {63'd0, bus.busy}, 64'd1);
    tick();
    tick();
    chk("mid_rst_busy_held", {63'd0, bus.busy}, 64'd1);
    rst = 1'b0;
    count_busy(cnt);
    chk("mid_rst_restart_cycles", cnt, 64'd32);
    bus.rd_addr2 = 5'd30;
    #1;
    chk("mid_rst_rd30", bus.rd_data2, 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/param_regfile.md
PARAM_REGFILE -- requirements
Module: param_regfile

Interface
REQ-001 SHALL have parameter DATA_W, default 64, register width in bits.
REQ-002 SHALL have parameter ADDR_W, default 5, address width; depth DEPTH = 2**ADDR_W.
REQ-003 SHALL have parameter ZERO_REG, default 1; 1 means entry 0 is hardwired to zero.
REQ-004 SHALL have port clk, input, 1, single clock; all state updates on rising edge.
REQ-005 SHALL have port rst, input, 1, reset, asynchronous, active-high.
REQ-006 SHALL have port wr_en, input, 1, write request.
REQ-007 SHALL have port wr_addr, input, ADDR_W, write address.
REQ-008 SHALL have port wr_data, input, DATA_W, write data.
REQ-009 SHALL have port rd_addr1, input, ADDR_W, read port 1 address.
REQ-010 SHALL have port rd_addr2, input, ADDR_W, read port 2 address.
REQ-011 SHALL have port rd_data1, output, DATA_W, read port 1 data.
REQ-012 SHALL have port rd_data2, output, DATA_W, read port 2 data.
REQ-013 SHALL have port clr_req, input, 1, request to zero the whole array.
REQ-014 SHALL have port busy, output, 1, high while the clear engine runs.
REQ-015 SHALL have port wr_drop, output, 1, registered one-cycle pulse: a write was discarded.

Function
REQ-016 SHALL drive rd_dataN combinationally from entry rd_addrN, zero latency, both ports independent.
REQ-017 SHALL, with ZERO_REG=1, return 0 for reads of entry 0 and silently discard writes to entry 0 (no wr_drop).
REQ-018 SHALL implement FSM states IDLE and CLEAR with an ADDR_W-bit clear index.
REQ-019 SHALL, in IDLE with wr_en=1, store wr_data at wr_addr on that clock edge.
REQ-020 SHALL, in IDLE with clr_req=1, enter CLEAR with index 0 on the next edge.
REQ-021 SHALL, in CLEAR, write zero to entry index each cycle and increment index.
REQ-022 SHALL return CLEAR to IDLE on the edge that clears entry DEPTH-1; a full clear takes exactly DEPTH cycles, with no index wrap.
REQ-023 SHALL hold busy=1 exactly while in CLEAR; busy is a decode of the state register.
REQ-024 SHALL, in CLEAR, discard wr_en and pulse wr_drop=1 in the following cycle.
REQ-025 SHALL ignore clr_req while in CLEAR, with no restart and no index reset.
REQ-026 SHALL, on wr_en and clr_req in the same IDLE cycle, perform the write, then start CLEAR, which later zeroes that entry.
REQ-027 SHALL let reads during CLEAR return current contents: zero for cleared entries, old data for the rest.

Reset
REQ-028 SHALL, while rst=1, force state CLEAR, index 0, wr_drop=0, busy=1, independent of clk.
REQ-029 SHALL NOT reset the storage array directly; after rst deasserts, the clear engine zeroes all DEPTH entries before busy falls.
REQ-030 SHALL, on rst asserted mid-clear, restart the clear from index 0.

Configuration
REQ-031 SHALL, with macro PARAM_REGFILE_BYPASS_EN defined and wr_en=1 in IDLE, return wr_data on any read port whose address equals wr_addr in that same cycle (write-first); ZERO_REG still forces 0 for entry 0.
REQ-032 SHALL, without PARAM_REGFILE_BYPASS_EN, return the pre-write stored value in that case; the new value is visible from the next cycle.

Verification
REQ-033 SHALL cover: pulse rst, release -> busy=1 for exactly 32 cycles, then 0; every entry reads 0.
REQ-034 SHALL cover: IDLE, write 0xDEADBEEF_CAFEF00D to entry 7 -> next cycle rd_data1(7) equals it; same-cycle rd_data2(7) is that value with bypass, 0 without.
REQ-035 SHALL cover: write 0x1234 to entry 0 (ZERO_REG=1) -> rd_data1(0)=0 and wr_drop=0.
REQ-036 SHALL cover: fill entries 1..31 with value=index; pulse clr_req; write 0xFF to entry 20 during CLEAR -> wr_drop pulses, entry 20 reads 0 after busy falls.
REQ-037 SHALL cover: wr_en to entry 3 plus clr_req in the same IDLE cycle -> entry 3 reads the new value one cycle, then 0 after the clear.
REQ-038 SHALL cover: assert rst at clear index 15 -> busy stays 1; after release, the clear completes 32 cycles later.
